// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counting timer with a programmable prescaler. Runs in
//   one-shot or periodic (auto-reload) mode and can be paused or stopped.
//   Emits a one-cycle expiry pulse each time the count reaches terminal.
//
// Ports
//   clock, reset      rising-edge clock; asynchronous active-high reset
//   i_Load_Valid      load request (accepted when o_Load_Ready is high)
//   o_Load_Ready      high in IDLE and DONE
//   i_Load_Value      initial / reload count
//   i_Prescale        tick every (i_Prescale + 1) cycles, latched on load
//   i_Periodic        1 = auto-reload, 0 = one-shot, latched on load
//   i_Start           start strobe
//   i_Pause           pause level
//   i_Stop            stop / abort strobe
//   o_Count           current count
//   o_Busy            RUN or PAUSED
//   o_Expired         one-cycle pulse on terminal count
//   o_Done            one-shot completed (level)
//
// State    | Meaning
// ---------+---------------------------------------------------------
// S_IDLE   | loaded or stopped, waiting for start; accepts loads
// S_RUN    | prescaler and count advancing
// S_PAUSED | count and prescale counter frozen while i_Pause is high
// S_DONE   | one-shot reached terminal; count 0, o_Done high; accepts loads

module countdown_timer #(
    parameter int WIDTH          = 16,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_Load_Valid,
    output logic                      o_Load_Ready,
    input  logic [WIDTH-1:0]          i_Load_Value,
    input  logic [PRESCALE_WIDTH-1:0] i_Prescale,
    input  logic                      i_Periodic,
    input  logic                      i_Start,
    input  logic                      i_Pause,
    input  logic                      i_Stop,
    output logic [WIDTH-1:0]          o_Count,
    output logic                      o_Busy,
    output logic                      o_Expired,
    output logic                      o_Done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] COUNT_ZERO = '0;
    localparam logic [WIDTH-1:0] COUNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t                    state_q, state_d;
    logic [WIDTH-1:0]          count_q, count_d;
    logic [WIDTH-1:0]          reload_q, reload_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
    logic                      periodic_q, periodic_d;
    logic                      expired_q, expired_d;
    logic                      done_q, done_d;

    logic load_ready;
    logic load_accept;
    logic run_step;

    assign load_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign load_accept = i_Load_Valid && load_ready;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        reload_d   = reload_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        periodic_d = periodic_q;
        expired_d  = 1'b0;
        done_d     = done_q;
        run_step   = 1'b0;

        if (load_accept) begin
            // A load wins over a same-cycle start and always lands in IDLE.
            reload_d   = i_Load_Value;
            count_d    = i_Load_Value;
            prescale_d = i_Prescale;
            periodic_d = i_Periodic;
            pcnt_d     = '0;
            done_d     = 1'b0;
            state_d    = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_Start && (count_q != COUNT_ZERO)) begin
                        state_d = S_RUN;
                        pcnt_d  = '0;
                    end
                end
                S_DONE: begin
                    if (i_Start && (reload_q != COUNT_ZERO)) begin
                        state_d = S_RUN;
                        count_d = reload_q;
                        pcnt_d  = '0;
                        done_d  = 1'b0;
                    end
                end
                S_RUN: begin
                    if (i_Stop) begin
                        state_d = S_IDLE;
                        count_d = reload_q;
                        pcnt_d  = '0;
                    end else if (i_Pause) begin
                        state_d = S_PAUSED;
                    end else begin
                        run_step = 1'b1;
                    end
                end
                S_PAUSED: begin
                    if (i_Stop) begin
                        state_d = S_IDLE;
                        count_d = reload_q;
                        pcnt_d  = '0;
                    end else if (!i_Pause) begin
                        // The resume edge counts, so a pause held for k edges
                        // delays expiry by exactly k cycles.
                        state_d  = S_RUN;
                        run_step = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (run_step) begin
            if (pcnt_q == prescale_q) begin
                pcnt_d = '0;
                if (count_q > COUNT_ONE) begin
                    count_d = count_q - COUNT_ONE;
                end else if (count_q == COUNT_ONE) begin
                    expired_d = 1'b1;
                    if (periodic_q) begin
                        count_d = reload_q;
                    end else begin
                        count_d = COUNT_ZERO;
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            reload_q   <= '0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            periodic_q <= 1'b0;
            expired_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            periodic_q <= periodic_d;
            expired_q  <= expired_d;
            done_q     <= done_d;
        end
    end

    assign o_Load_Ready = load_ready;
    assign o_Busy       = (state_q == S_RUN) || (state_q == S_PAUSED);
    assign o_Count      = count_q;
    assign o_Expired    = expired_q;
    assign o_Done       = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    logic        clock;
    logic        reset;
    logic        i_Load_Valid;
    logic        o_Load_Ready;
    logic [15:0] i_Load_Value;
    logic [7:0]  i_Prescale;
    logic        i_Periodic;
    logic        i_Start;
    logic        i_Pause;
    logic        i_Stop;
    logic [15:0] o_Count;
    logic        o_Busy;
    logic        o_Expired;
    logic        o_Done;

    countdown_timer #(.WIDTH(16), .PRESCALE_WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .i_Load_Valid (i_Load_Valid),
        .o_Load_Ready (o_Load_Ready),
        .i_Load_Value (i_Load_Value),
        .i_Prescale   (i_Prescale),
        .i_Periodic   (i_Periodic),
        .i_Start      (i_Start),
        .i_Pause      (i_Pause),
        .i_Stop       (i_Stop),
        .o_Count      (o_Count),
        .o_Busy       (o_Busy),
        .o_Expired    (o_Expired),
        .o_Done       (o_Done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int exp_q[$];   // cycle numbers at which o_Expired is expected

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; sample #1 after it and score any expiry pulse.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (o_Expired === 1'b1) begin
            if (exp_q.size() == 0) chk("expiry_unexpected", {31'd0, o_Expired}, 32'd0);
            else                   chk("expiry_cycle", cyc, exp_q.pop_front());
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        chk("expiry_missing", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic load(input int val, input int pre, input logic per);
        i_Load_Valid = 1'b1;
        i_Load_Value = val[15:0];
        i_Prescale   = pre[7:0];
        i_Periodic   = per;
        step();
        i_Load_Valid = 1'b0;
    endtask

    // Start at the next edge (E0) and schedule the expected expiries.
    task automatic start_run(input int n, input int p, input int periods);
        for (int k = 1; k <= periods; k++) exp_q.push_back(cyc + 1 + k * n * (p + 1));
        i_Start = 1'b1;
        step();
        i_Start = 1'b0;
    endtask

    int frozen;
    int exp_cnt;

    initial begin
        reset = 1'b1;
        i_Load_Valid = 1'b0; i_Load_Value = '0; i_Prescale = '0; i_Periodic = 1'b0;
        i_Start = 1'b0; i_Pause = 1'b0; i_Stop = 1'b0;
        #12;
        chk("rst_count", o_Count, 0);
        chk("rst_busy",  o_Busy, 0);
        chk("rst_ready", o_Load_Ready, 1);
        chk("rst_exp",   o_Expired, 0);
        chk("rst_done",  o_Done, 0);
        @(negedge clock);
        reset = 1'b0;
        step();

        // One-shot: load 3, prescale 0
        load(3, 0, 1'b0);
        chk("os_loaded", o_Count, 3);
        start_run(3, 0, 1);
        chk("os_busy", o_Busy, 1);
        chk("os_ready_run", o_Load_Ready, 0);
        step(); chk("os_c1", o_Count, 2);
        step(); chk("os_c2", o_Count, 1);
        step(); chk("os_c3", o_Count, 0);
        chk("os_exp_pulse", o_Expired, 1);
        chk("os_done", o_Done, 1);
        chk("os_idle", o_Busy, 0);
        chk("os_ready", o_Load_Ready, 1);
        step(); chk("os_exp_clear", o_Expired, 0);
        drain();

        // DONE + start reruns the reload value
        start_run(3, 0, 1);
        chk("rerun_count", o_Count, 3);
        chk("rerun_done_clr", o_Done, 0);
        steps(3);
        chk("rerun_done", o_Done, 1);
        drain();

        // Periodic: load 2, prescale 1, five periods
        load(2, 1, 1'b1);
        start_run(2, 1, 5);
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_cnt = ((k % 4) == 2 || (k % 4) == 3) ? 1 : 2;
            chk("per_count", o_Count, exp_cnt);
            chk("per_busy", o_Busy, 1);
        end
        i_Stop = 1'b1; step(); i_Stop = 1'b0;
        chk("per_stop_busy", o_Busy, 0);
        chk("per_stop_count", o_Count, 2);
        steps(3);
        drain();

        // Baseline: load 5, prescale 3 -> expiry 20 cycles after start
        load(5, 3, 1'b0);
        start_run(5, 3, 1);
        steps(20);
        chk("base_done", o_Done, 1);
        drain();

        // Same with a 10-cycle pause -> expiry at 30
        load(5, 3, 1'b0);
        exp_q.push_back(cyc + 1 + 30);
        i_Start = 1'b1; step(); i_Start = 1'b0;
        steps(6);
        frozen = o_Count;
        chk("pause_pre", o_Count, 4);
        i_Pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pause_frozen", o_Count, frozen);
            chk("pause_busy", o_Busy, 1);
        end
        i_Pause = 1'b0;
        steps(14);
        chk("pause_done", o_Done, 1);
        drain();

        // Pause and stop together -> IDLE with reload value
        load(5, 3, 1'b0);
        start_run(5, 3, 0);
        steps(5);
        i_Pause = 1'b1; i_Stop = 1'b1; step(); i_Pause = 1'b0; i_Stop = 1'b0;
        chk("ps_busy", o_Busy, 0);
        chk("ps_count", o_Count, 5);
        chk("ps_ready", o_Load_Ready, 1);
        steps(25);
        drain();

        // Load during RUN is ignored
        load(4, 0, 1'b0);
        start_run(4, 0, 1);
        chk("lr_ready", o_Load_Ready, 0);
        i_Load_Valid = 1'b1; i_Load_Value = 16'd9;
        step(); i_Load_Valid = 1'b0;
        chk("lr_count", o_Count, 3);
        steps(3);
        chk("lr_done", o_Done, 1);
        drain();

        // Start with count 0 is ignored
        load(0, 0, 1'b0);
        i_Start = 1'b1; step(); i_Start = 1'b0;
        chk("z_busy", o_Busy, 0);
        chk("z_count", o_Count, 0);

        // Load + start same cycle -> IDLE with new value; next start runs
        i_Load_Valid = 1'b1; i_Load_Value = 16'd3; i_Prescale = 8'd0; i_Periodic = 1'b0;
        i_Start = 1'b1;
        step();
        i_Load_Valid = 1'b0; i_Start = 1'b0;
        chk("ls_busy", o_Busy, 0);
        chk("ls_count", o_Count, 3);
        start_run(3, 0, 1);
        chk("ls_run", o_Busy, 1);
        steps(3);
        chk("ls_done", o_Done, 1);
        drain();

        // Load 1, prescale 0, periodic -> expiry every cycle
        load(1, 0, 1'b1);
        start_run(1, 0, 6);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("p1_count", o_Count, 1);
            chk("p1_exp", o_Expired, 1);
        end
        i_Stop = 1'b1; step(); i_Stop = 1'b0;
        chk("p1_stop", o_Busy, 0);
        steps(2);
        drain();

        // Reset mid-RUN with count 7
        load(7, 3, 1'b0);
        start_run(7, 3, 0);
        steps(2);
        chk("mr_pre", o_Count, 7);
        #2 reset = 1'b1;
        #1;
        chk("mr_count", o_Count, 0);
        chk("mr_busy", o_Busy, 0);
        chk("mr_ready", o_Load_Ready, 1);
        chk("mr_exp", o_Expired, 0);
        steps(2);
        @(negedge clock);
        reset = 1'b0;
        steps(3);
        chk("mr_after_busy", o_Busy, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counting timer with a programmable prescaler, one-shot and periodic modes, and pause/stop control.
- Emits a single-cycle expiry pulse when the count reaches terminal.
- Used by sensor-poll and display-refresh sequencers as the timed counterpart of the free-running modulo up-counters.
- Configured through a valid/ready load handshake; controlled by start/pause/stop strobes.

Parameters:
- WIDTH, 16, width of count and load value.
- PRESCALE_WIDTH, 8, width of prescale divisor field.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- i_Load_Valid  in  1  load request.
- o_Load_Ready  out  1  block accepts a load this cycle.
- i_Load_Value  in  WIDTH  initial/reload count.
- i_Prescale  in  PRESCALE_WIDTH  tick every (i_Prescale+1) cycles.
- i_Periodic  in  1  1 = auto-reload mode, 0 = one-shot; latched on load.
- i_Start  in  1  start strobe.
- i_Pause  in  1  pause level.
- i_Stop  in  1  stop/abort strobe.
- o_Count  out  WIDTH  current count.
- o_Busy  out  1  state is RUN or PAUSED.
- o_Expired  out  1  one-cycle pulse on terminal count.
- o_Done  out  1  one-shot completed (level).

Behaviour:
- Reset is asynchronous, active-high, on clock. While reset is high:
  - state = IDLE; count, reload register, prescale register, prescale counter and periodic flag = 0.
  - o_Busy = 0, o_Expired = 0, o_Done = 0, o_Load_Ready = 1.
- All outputs are registered or decoded directly from registered state; no combinational path from inputs to outputs.
- States: IDLE, RUN, PAUSED, DONE.
- o_Load_Ready = 1 in IDLE and DONE, 0 in RUN and PAUSED.
- Load accept (i_Load_Valid & o_Load_Ready at an edge):
  - reload register and count <= i_Load_Value; prescale register <= i_Prescale; periodic flag <= i_Periodic.
  - prescale counter <= 0; state <= IDLE; o_Done <= 0.
  - New count visible on o_Count the next cycle.
  - i_Start in the same cycle is ignored.
  - i_Load_Valid while not ready is ignored; no state change.
- IDLE:
  - i_Start with count != 0 -> RUN, prescale counter <= 0.
  - i_Start with count == 0 is ignored.
  - i_Pause and i_Stop have no effect.
- RUN, priority Stop > Pause > tick:
  - i_Stop -> IDLE; count <= reload register; prescale counter <= 0; no o_Expired.
  - Else i_Pause -> PAUSED; count and prescale counter hold; no tick this edge.
  - Else if prescale counter == prescale register: tick; prescale counter <= 0.
  - Otherwise the prescale counter increments.
  - Prescale 0 ticks every cycle.
- Tick:
  - count > 1: count <= count-1.
  - count == 1, one-shot: count <= 0, state <= DONE, o_Done <= 1, o_Expired <= 1 for one cycle.
  - count == 1, periodic: count <= reload register, stay RUN, o_Expired <= 1 for one cycle.
- Timing: with start sampled at edge E0, the first tick is at edge E(p+1), p = prescale. Expiry follows N*(p+1) cycles after E0 for load value N. Periodic expiry period is N*(p+1) cycles, with no gap cycle.
- PAUSED:
  - i_Stop -> IDLE with the same actions as stop from RUN.
  - Else i_Pause low -> RUN; counting resumes from the held prescale counter.
  - i_Start is ignored.
- DONE:
  - o_Done held at 1; count holds 0.
  - i_Start -> RUN with count <= reload register, o_Done <= 0. A zero reload register is ignored.
  - Load accept also leaves DONE (see above).
- o_Busy = 1 exactly when state is RUN or PAUSED.
- Reset asserted mid-operation aborts immediately to the reset values, with no o_Expired.
- Count arithmetic wraps never: 0 is only reached via terminal count in one-shot mode.

Test Plan:
- Reset mid-RUN, count 7 -> outputs go to reset values immediately (o_Count=0, o_Busy=0, o_Load_Ready=1); no o_Expired.
- Load 3, prescale 0, one-shot; start at E0 -> o_Count 2,1,0 after E1,E2,E3; o_Expired high only in the cycle after E3; o_Done=1; o_Busy=0; o_Load_Ready=1.
- Load 2, prescale 1, periodic; start -> o_Expired pulses every 4 cycles for 5 periods; o_Count sequence 2,2,1,1,2,...; o_Busy stays 1.
- Load 5, prescale 3; start; hold i_Pause 10 cycles mid-count -> o_Count frozen; expiry delayed by exactly 10 cycles vs. the 20-cycle baseline. Assert i_Pause and i_Stop together -> IDLE, o_Count=5, no expiry.
- Load during RUN -> o_Load_Ready=0 and no change. Start with count 0 -> remains IDLE. Load plus start in the same cycle -> IDLE with the new value; a following start runs.
- In DONE, start -> reruns the reload value. Load 1, prescale 0, periodic -> o_Expired high every cycle, o_Count constant 1.
